vic_prio: RTL and testbench

Parametrised vectored interrupt controller, the successor to the two-channel VIC on the BK CPU's VIRQ/IAKO path. It accepts N request lines and supports per-channel edge or level mode, per-channel masking and fixed index priority. During an interrupt-acknowledge bus cycle it returns the winning channel's vector and pulses that channel's acknowledge. It sits between peripheral request sources (video, disk, timer, PSG) and `vm1_se` `pin_virq`/`pin_din`, and its output joins the `cpu_din` wired-OR.

---
 rtl/vic_prio_pkg.sv | 17 +
 rtl/vic_prio_enc.sv | 26 ++
 rtl/vic_prio.sv | 101 ++++++++++
 tb/tb_vic_prio.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vic_prio_pkg.sv
// Shared types and helpers for the vectored interrupt controller.
package vic_prio_pkg;

  localparam int VIC_MAX_N = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LATCH,
    ST_HOLD
  } vic_state_t;

  // Index width for an N-channel controller, never narrower than one bit.
  function automatic int vic_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vic_prio_enc.sv
// Highest-index-wins priority encoder over the eligible request vector.
// Latency: combinational.
// Backpressure: none; pure function of req.
module vic_prio_enc
  import vic_prio_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = vic_idx_w(N)
) (
  input  logic [N-1:0]  req,
  output logic          vld,
  output logic [IW-1:0] idx
);

  always_comb begin
    vld = 1'b0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        vld = 1'b1;
        idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/vic_prio.sv
// Vectored interrupt controller: edge/level pending, masking, fixed index priority.
// Latency: request to virq 2 ce; stb to dat_o 1 ce, to ack/iack 2 ce.
// Backpressure: ack/dat_o held until stb is sampled low; stb stuck high after reset is ignored.
module vic_prio
  import vic_prio_pkg::*;
#(
  parameter int          N    = 2,
  parameter logic [15:0] SPUR = 16'o000000
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            ce,
  input  logic [N*16-1:0] ivec,
  input  logic [N-1:0]    ireq,
  input  logic [N-1:0]    edge_mode,
  input  logic [N-1:0]    mask,
  input  logic            stb,
  output logic            virq,
  output logic [15:0]     dat_o,
  output logic            ack,
  output logic [N-1:0]    iack
);

  localparam int IW = vic_idx_w(N);

  vic_state_t    state;
  logic [N-1:0]  pend;
  logic [N-1:0]  ireq_q;
  logic [N-1:0]  elig;
  logic [N-1:0]  sel_oh;
  logic [N-1:0]  clr;
  logic [IW-1:0] sel;
  logic [IW-1:0] win_idx;
  logic          win_vld;
  logic          spur;
  logic          armed;

  assign elig = pend & ~mask;

  vic_prio_enc #(.N(N), .IW(IW)) u_enc (
    .req (elig),
    .vld (win_vld),
    .idx (win_idx)
  );

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < N; i++) begin
      sel_oh[i] = (sel == IW'(i));
    end
  end

  // Clear fires on the same ce that raises iack, so virq drops one ce later.
  assign clr = (state == ST_LATCH && !spur) ? sel_oh : '0;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state  <= ST_IDLE;
      pend   <= '0;
      ireq_q <= '0;
      sel    <= '0;
      spur   <= 1'b0;
      armed  <= 1'b0;
      virq   <= 1'b0;
      dat_o  <= '0;
      ack    <= 1'b0;
      iack   <= '0;
    end else if (ce) begin
      ireq_q <= ireq;
      // A fresh edge beats a same-cycle acknowledge clear.
      pend   <= (edge_mode & ((ireq & ~ireq_q) | (pend & ~clr))) | (~edge_mode & ireq);
      virq   <= |elig;
      iack   <= '0;
      if (!stb) armed <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (stb && armed) begin
            sel   <= win_idx;
            spur  <= !win_vld;
            dat_o <= win_vld ? ivec[16*int'(win_idx) +: 16] : SPUR;
            state <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          ack   <= 1'b1;
          iack  <= clr;
          state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (!stb) begin
            ack   <= 1'b0;
            dat_o <= '0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vic_prio.sv
// Directed-vector bench for vic_prio with a queue scoreboard on acknowledge cycles.
module tb_vic_prio;

  localparam int          N    = 4;
  localparam logic [15:0] SPUR = 16'o000777;

  logic            clk_sys = 1'b0;
  logic            reset   = 1'b1;
  logic            ce      = 1'b1;
  logic            stb     = 1'b0;
  logic [N*16-1:0] ivec    = {16'o000300, 16'o000200, 16'o000060, 16'o000274};
  logic [N-1:0]    ireq      = '0;
  logic [N-1:0]    edge_mode = 4'b1011;
  logic [N-1:0]    mask      = '0;
  logic            virq;
  logic [15:0]     dat_o;
  logic            ack;
  logic [N-1:0]    iack;

  vic_prio #(.N(N), .SPUR(SPUR)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ce        (ce),
    .ivec      (ivec),
    .ireq      (ireq),
    .edge_mode (edge_mode),
    .mask      (mask),
    .stb       (stb),
    .virq      (virq),
    .dat_o     (dat_o),
    .ack       (ack),
    .iack      (iack)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [15:0]  dat;
    logic [N-1:0] iack;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  logic ack_q = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0o expected %0o", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Monitor: every rising ack must match the oldest queued expectation.
  always @(negedge clk_sys) begin
    if (ack && !ack_q) begin
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_ack: got dat %0o iack %b expected no acknowledge", dat_o, iack);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (dat_o !== e.dat || iack !== e.iack) begin
          fails++;
          $display("FAIL sb_ack: got dat %0o iack %b expected dat %0o iack %b",
                   dat_o, iack, e.dat, e.iack);
        end
      end
    end else if (iack !== '0) begin
      tests++;
      fails++;
      $display("FAIL stray_iack: got %b expected 0", iack);
    end
    ack_q = ack;
  end

  task automatic do_ack(input logic [15:0] d, input logic [N-1:0] ia);
    sbq.push_back('{dat: d, iack: ia});
    stb = 1'b1;
    tick();
    check("dat_latched", 32'(dat_o), 32'(d));
    tick();
    tick();
    stb = 1'b0;
    tick();
    check("ack_released", 32'(ack), 0);
    check("dat_released", 32'(dat_o), 0);
    tick();
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_virq", 32'(virq), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_dat", 32'(dat_o), 0);
    check("rst_iack", 32'(iack), 0);
    reset = 1'b0;
    tick();

    // Single edge request on ch0
    ireq[0] = 1'b1;
    tick();
    check("t1_virq_early", 32'(virq), 0);
    ireq[0] = 1'b0;
    tick();
    check("t1_virq", 32'(virq), 1);
    do_ack(16'o000274, 4'b0001);
    check("t1_virq_after", 32'(virq), 0);

    // ch1 and ch3 together: highest index first
    ireq[1] = 1'b1;
    ireq[3] = 1'b1;
    tick();
    ireq[1] = 1'b0;
    ireq[3] = 1'b0;
    tick();
    check("t2_virq", 32'(virq), 1);
    do_ack(16'o000300, 4'b1000);
    check("t2_virq_mid", 32'(virq), 1);
    do_ack(16'o000060, 4'b0010);
    check("t2_virq_after", 32'(virq), 0);

    // Level ch2 held through acknowledge
    ireq[2] = 1'b1;
    tick();
    tick();
    check("t3_virq", 32'(virq), 1);
    do_ack(16'o000200, 4'b0100);
    check("t3_virq_held", 32'(virq), 1);
    ireq[2] = 1'b0;
    tick();
    tick();
    check("t3_virq_drop", 32'(virq), 0);

    // Masked pending edge ch2: spurious ack, then unmask
    edge_mode = 4'b1111;
    mask      = 4'b0100;
    ireq[2]   = 1'b1;
    tick();
    ireq[2]   = 1'b0;
    tick();
    tick();
    check("t4_virq_masked", 32'(virq), 0);
    do_ack(SPUR, 4'b0000);
    mask = 4'b0000;
    tick();
    check("t4_virq_unmask", 32'(virq), 1);
    do_ack(16'o000200, 4'b0100);
    check("t4_virq_after", 32'(virq), 0);

    // New ch0 edge on the same ce as iack[0]
    ireq[0] = 1'b1;
    tick();
    ireq[0] = 1'b0;
    tick();
    sbq.push_back('{dat: 16'o000274, iack: 4'b0001});
    stb = 1'b1;
    tick();
    ireq[0] = 1'b1;
    tick();
    ireq[0] = 1'b0;
    tick();
    stb = 1'b0;
    tick();
    tick();
    check("t5_virq_kept", 32'(virq), 1);
    do_ack(16'o000274, 4'b0001);
    check("t5_virq_after", 32'(virq), 0);

    // ce low freezes sampling and the FSM
    ireq[1] = 1'b1;
    ce      = 1'b0;
    tick();
    tick();
    check("ce_virq_frozen", 32'(virq), 0);
    ce = 1'b1;
    tick();
    ireq[1] = 1'b0;
    tick();
    check("ce_virq", 32'(virq), 1);
    stb = 1'b1;
    ce  = 1'b0;
    tick();
    tick();
    check("ce_dat_frozen", 32'(dat_o), 0);
    check("ce_ack_frozen", 32'(ack), 0);
    stb = 1'b0;
    ce  = 1'b1;
    tick();
    do_ack(16'o000060, 4'b0010);

    // Reset in HOLD with stb held high
    ireq[3] = 1'b1;
    tick();
    ireq[3] = 1'b0;
    tick();
    sbq.push_back('{dat: 16'o000300, iack: 4'b1000});
    stb = 1'b1;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rh_ack", 32'(ack), 0);
    check("rh_dat", 32'(dat_o), 0);
    check("rh_virq", 32'(virq), 0);
    tick();
    tick();
    tick();
    check("rh_no_reack", 32'(ack), 0);
    check("rh_no_dat", 32'(dat_o), 0);
    stb = 1'b0;
    tick();
    ireq[0] = 1'b1;
    tick();
    ireq[0] = 1'b0;
    tick();
    do_ack(16'o000274, 4'b0001);
    check("rh_virq_after", 32'(virq), 0);

    tick();
    check("sb_empty", 32'(sbq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
